mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the multiply-sequence engine (2..8).
REQ-002 Parameter DW, default 8, operand width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request; bit i SHALL be held high until accepted.
REQ-006 req_data  input  NREQ*DW  operand of requester i in bits [i*DW +: DW].
REQ-007 req_ready  output  NREQ  one-hot grant; bit i high = requester i accepted this cycle.
REQ-008 out_valid  output  1  result word valid.
REQ-009 out  output  DW+3  result word.
REQ-010 out_phase  output  2  multiplier index of out: 0 = x1, 1 = x3, 2 = x7, 3 = x8.
REQ-011 out_id  output  clog2(NREQ)  requester that owns the current result.
REQ-012 busy  output  1  engine holds an operand (phases pending).

Function
REQ-013 The engine SHALL have states IDLE, P1, P3, P7, P8.
REQ-014 An accept SHALL occur when the state is IDLE or P8 and at least one req_valid is high.
REQ-015 On an accept, exactly one req_ready bit SHALL be high, combinationally in the same cycle.
REQ-016 At most one req_ready bit SHALL ever be high; all req_ready bits SHALL be low in P1, P3 and P7.
REQ-017 Winner selection SHALL be round-robin: search starts at pointer ptr, wrapping NREQ-1 -> 0.
REQ-018 On each accept, ptr SHALL be updated to winner+1 modulo NREQ; otherwise ptr SHALL hold.
REQ-019 On accept, the engine SHALL register the winner's operand and id and enter P1 on the next edge.
REQ-020 Out SHALL be registered; one cycle after entering P1 the first result word SHALL appear.
REQ-021 In P1 the block SHALL drive out = d, out_phase = 0, and out_valid = 1.
REQ-022 In P3 the block SHALL drive out = 3*d, out_phase = 1, and out_valid = 1.
REQ-023 In P7 the block SHALL drive out = 7*d, out_phase = 2, and out_valid = 1.
REQ-024 In P8 the block SHALL drive out = 8*d, out_phase = 3, and out_valid = 1.
REQ-025 Multiples SHALL be formed by shift/add/subtract on the latched operand, never a multiplier, zero-extended to DW+3 bits with no overflow.
REQ-026 Latency: accept in cycle T SHALL give the x1 word in cycle T+1 and the x8 word in cycle T+4.
REQ-027 An accept in P8 SHALL go to P1 with no idle gap, giving back-to-back operations every 4 cycles.
REQ-028 With no accept in P8, the state SHALL return to IDLE.
REQ-029 In IDLE, out_valid SHALL be 0; out, out_phase and out_id SHALL hold their last values.
REQ-030 busy SHALL be 1 in P1, P3, P7 and P8, and 0 in IDLE.
REQ-031 A req_valid deasserted before its accept SHALL be ignored without error; req_data SHALL be sampled only in the accept cycle.

Reset
REQ-032 While rst is high: state IDLE, ptr 0, latched operand 0, id 0.
REQ-033 While rst is high, every output SHALL be 0, including req_ready, independent of clk.
REQ-034 Reset asserted mid-operation SHALL abort the operand; its remaining phases SHALL never be emitted.
REQ-035 After rst falls, the first accept SHALL be possible in the first clock cycle.

Structure
REQ-036 Package mul_sched_pkg SHALL hold the state enum, the phase codes (PH_X1..PH_X8) and the default NREQ/DW constants.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; outputs: one-hot grant, winner index).
REQ-038 The sequencing FSM and the datapath SHALL live in mul_sched.

Verification
REQ-039 Single request: DW=8, req_valid=0001, data 0x05 -> out 5, 15, 35, 40 on cycles T+1..T+4, out_id 0, then out_valid low.
REQ-040 Maximum operand: data 0xFF -> out 255, 765, 1785, 2040 with no truncation in the 11-bit output.
REQ-041 All four requesters held valid -> grant order 0,1,2,3,0..., one accept every 4 cycles, no gap on out_valid.
REQ-042 Requester 2 alone then requester 1 alone, with ptr at 3 -> wrap-around grants 1 before any later request from 2.
REQ-043 rst pulsed during P3 -> outputs zero immediately; no P7/P8 words after release; the next accept starts at ptr 0.
REQ-044 Bench SHALL assert every cycle: req_ready one-hot or zero, and req_ready nonzero only in IDLE or P8.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// ============================================================================
// Module      : mul_sched_pkg
// Description : Shared types and constants for the multiply-sequence scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P3   = 3'd2,
        ST_P7   = 3'd3,
        ST_P8   = 3'd4
    } state_t;

    localparam logic [1:0] PH_X1 = 2'd0;
    localparam logic [1:0] PH_X3 = 2'd1;
    localparam logic [1:0] PH_X7 = 2'd2;
    localparam logic [1:0] PH_X8 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mul_sched_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin selector; search starts at i_ptr and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_sched.sv
// ============================================================================
// Module      : mul_sched
// Description : Shared engine emitting x1, x3, x7, x8 of each accepted operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [DW+2:0]      out,
    output logic [1:0]         out_phase,
    output logic [IW-1:0]      out_id,
    output logic               busy
);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_win_idx;
    logic [IW-1:0]   w_ptr_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic [DW-1:0]   r_d;
    logic [DW-1:0]   w_win_data;
    logic [DW+2:0]   w_win_ext;
    logic [DW+2:0]   w_d_ext;
    logic [DW+2:0]   w_x3;
    logic [DW+2:0]   w_x7;
    logic [DW+2:0]   w_x8;
    logic [DW+2:0]   r_out;
    logic [1:0]      r_phase;
    logic            r_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx)
    );

    assign w_win_data = req_data[w_win_idx*DW +: DW];
    assign w_win_ext  = {3'b000, w_win_data};
    assign w_ptr_next = (w_win_idx == IW'(NREQ-1)) ? '0 : w_win_idx + 1'b1;

    // Extra three bits absorb the x8 multiple, so no product can overflow.
    assign w_d_ext = {3'b000, r_d};
    assign w_x3    = (w_d_ext << 1) + w_d_ext;
    assign w_x7    = (w_d_ext << 3) - w_d_ext;
    assign w_x8    = w_d_ext << 3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_P1;
                end
            end
            ST_P1:   w_next = ST_P3;
            ST_P3:   w_next = ST_P7;
            ST_P7:   w_next = ST_P8;
            ST_P8: begin
                if (|req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_P1;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Grant is masked during reset so no requester sees a phantom accept.
        if (w_accept && !rst) begin
            req_ready = w_grant;
        end
    end

    // Output registers load the word belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_d     <= '0;
            r_out   <= '0;
            r_phase <= PH_X1;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_d   <= w_win_data;
                r_id  <= w_win_idx;
                r_ptr <= w_ptr_next;
            end
            case (w_next)
                ST_P1: begin
                    r_out   <= w_win_ext;
                    r_phase <= PH_X1;
                    r_valid <= 1'b1;
                end
                ST_P3: begin
                    r_out   <= w_x3;
                    r_phase <= PH_X3;
                    r_valid <= 1'b1;
                end
                ST_P7: begin
                    r_out   <= w_x7;
                    r_phase <= PH_X7;
                    r_valid <= 1'b1;
                end
                ST_P8: begin
                    r_out   <= w_x8;
                    r_phase <= PH_X8;
                    r_valid <= 1'b1;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign out       = r_out;
    assign out_phase = r_phase;
    assign out_valid = r_valid;
    assign out_id    = r_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
// ============================================================================
// Module      : tb_mul_sched
// Description : Directed scoreboard bench for mul_sched (NREQ=4, DW=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*DW-1:0]  req_data  = '0;
    logic [NREQ-1:0]     req_ready;
    logic                out_valid;
    logic [DW+2:0]       out;
    logic [1:0]          out_phase;
    logic [1:0]          out_id;
    logic                busy;

    typedef struct packed {
        logic [1:0]  id;
        logic [1:0]  ph;
        logic [10:0] val;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_sched #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out       (out),
        .out_phase (out_phase),
        .out_id    (out_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic push_op(input logic [1:0] id);
        logic [10:0] d;
        exp_t        e;
        d = 11'(req_data[id*DW +: DW]);
        e.id = id;
        e.ph = 2'd0; e.val = 11'(d * 1); q.push_back(e);
        e.ph = 2'd1; e.val = 11'(d * 3); q.push_back(e);
        e.ph = 2'd2; e.val = 11'(d * 7); q.push_back(e);
        e.ph = 2'd3; e.val = 11'(d * 8); q.push_back(e);
    endtask

    // One cycle: check registered out_valid, drive valids, check the grant.
    task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy,
                        input int exp_ov, input string tag);
        @(negedge clk);
        if (exp_ov >= 0) chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_ov));
        req_valid = v;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) push_op(oh2idx(exp_rdy));
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            chk("word_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                m_e = q.pop_front();
                chk("out", 32'(out), 32'(m_e.val));
                chk("out_phase", 32'(out_phase), 32'(m_e.ph));
                chk("out_id", 32'(out_id), 32'(m_e.id));
            end
        end
    end

    always @(negedge clk) begin
        #3;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        chk("ready_only_idle_p8",
            32'((req_ready == '0) || !busy || (out_valid && out_phase == 2'd3)), 32'd1);
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout, required $finish");
        $fatal(1);
    end

    initial begin
        req_data  = {8'h80, 8'h11, 8'hFF, 8'h05};
        req_valid = 4'b1111;
        #1 rst = 1'b1;
        #2;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out", 32'(out), 32'd0);
        chk("rst out_phase", 32'(out_phase), 32'd0);
        chk("rst out_id", 32'(out_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("rst clocked req_ready", 32'(req_ready), 32'd0);
        chk("rst clocked out_valid", 32'(out_valid), 32'd0);

        // Single request, accepted in the first cycle after reset release.
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("first_accept req_ready", 32'(req_ready), 32'b0001);
        push_op(2'd0);
        repeat (4) step(4'b0000, 4'b0000, 1, "single");
        step(4'b0010, 4'b0010, 0, "max_grant");
        chk("idle hold out", 32'(out), 32'd40);
        chk("idle hold out_phase", 32'(out_phase), 32'd3);
        chk("idle hold out_id", 32'(out_id), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);

        // Maximum operand 0xFF on requester 1.
        repeat (4) step(4'b0000, 4'b0000, 1, "max");

        // Requester 2, then 1 wraps ahead of a renewed request from 2.
        step(4'b0100, 4'b0100, 0, "wrap_r2");
        repeat (3) step(4'b0010, 4'b0000, 1, "wrap_hold1");
        step(4'b0110, 4'b0010, 1, "wrap_r1");
        repeat (3) step(4'b0100, 4'b0000, 1, "wrap_hold2");
        step(4'b0100, 4'b0100, 1, "wrap_r2b");
        repeat (4) step(4'b0000, 4'b0000, 1, "wrap_drain");

        // Reset during P3 of requester 3.
        step(4'b1000, 4'b1000, 0, "r3_grant");
        step(4'b0000, 4'b0000, 1, "r3_p1");
        @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        req_valid = 4'b1111;
        #1;
        chk("midrst out", 32'(out), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_phase", 32'(out_phase), 32'd0);
        chk("midrst out_id", 32'(out_id), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst clocked out_valid", 32'(out_valid), 32'd0);

        // All four held valid: grants 0,1,2,3,0,... back to back from ptr 0.
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rr_first req_ready", 32'(req_ready), 32'b0001);
        push_op(2'd0);
        for (int k = 1; k < 8; k++) begin
            repeat (3) step(4'b1111, 4'b0000, 1, "rr_hold");
            step(4'b1111, 4'(1 << (k % 4)), 1, "rr_grant");
        end
        repeat (4) step(4'b0000, 4'b0000, 1, "rr_tail");
        step(4'b0000, 4'b0000, 0, "rr_idle");
        repeat (3) step(4'b0000, 4'b0000, 0, "final_idle");
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
